// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage and its MEM/WB register.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mem_stage_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regsel_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Writeback source select
  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC  = 2'd2
  } wb_sel_t;

  // MEM/WB register contents
  typedef struct packed {
    logic    valid;
    word_t   data;
    regsel_t regsel;
    logic    reg_write;
    logic    halt;
  } wb_t;

  function automatic word_t wb_mux(input wb_sel_t sel, input word_t alu,
                                   input word_t rdata, input word_t pc);
    word_t r;
    case (sel)
      WB_SEL_MEM: r = rdata;
      WB_SEL_PC:  r = pc;
      default:    r = alu;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundles the EX/MEM inputs, data-memory handshake, hazard and writeback signals.
// Latency: n/a (wiring only).
// Backpressure: stall_out is the upstream freeze; mem_done is the memory's completion.
interface mem_stage_if;
  import mem_stage_pkg::*;

  // EX/MEM register outputs
  logic    valid_in;
  word_t   aluResult_in;
  word_t   B_in;
  word_t   nextPC_in;
  word_t   newPC_in;
  regsel_t regsel_in;
  logic    enJAL_in;
  logic    branch_in;
  logic    mem_to_reg_in;
  logic    memWrite_in;
  logic    regWrite_in;
  logic    halt_in;

  // Data memory
  word_t   mem_addr;
  word_t   mem_wdata;
  logic    mem_rd;
  logic    mem_wr;
  word_t   mem_rdata;
  logic    mem_done;

  // Hazard / redirect / forwarding
  logic    stall_out;
  logic    pc_redirect;
  word_t   pc_target;
  logic    fwd_valid;
  regsel_t fwd_regsel;
  word_t   fwd_data;

  // MEM/WB outputs
  logic    wb_valid;
  word_t   wb_data;
  regsel_t wb_regsel;
  logic    wb_regWrite;
  logic    wb_halt;
  logic    err;

  modport slave (
    input  valid_in, aluResult_in, B_in, nextPC_in, newPC_in, regsel_in,
           enJAL_in, branch_in, mem_to_reg_in, memWrite_in, regWrite_in, halt_in,
           mem_rdata, mem_done,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
           stall_out, pc_redirect, pc_target, fwd_valid, fwd_regsel, fwd_data,
           wb_valid, wb_data, wb_regsel, wb_regWrite, wb_halt, err
  );

  modport master (
    output valid_in, aluResult_in, B_in, nextPC_in, newPC_in, regsel_in,
           enJAL_in, branch_in, mem_to_reg_in, memWrite_in, regWrite_in, halt_in,
           mem_rdata, mem_done,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
           stall_out, pc_redirect, pc_target, fwd_valid, fwd_regsel, fwd_data,
           wb_valid, wb_data, wb_regsel, wb_regWrite, wb_halt, err
  );

endinterface

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register with bubble insert.
// Latency: 1 cycle (loads every edge).
// Backpressure: none; bubble clears valid/reg_write and holds the rest, so halt stays sticky.
module mem_stage_memwb_reg
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bubble,
  input  wb_t  d,
  output wb_t  q
);

  // Load the instruction, or insert a bubble that keeps payload fields unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q.valid     <= 1'b0;
      q.reg_write <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory handshake, branch redirect, EX forward path, MEM/WB register.
// Latency: 1 cycle EX/MEM->MEM/WB for zero-wait access, N+1 when mem_done comes N cycles late.
// Backpressure: stall_out holds upstream while an access waits, and forever once halted.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
)
(
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
);

  localparam cnt_t TIMEOUT_CNT = cnt_t'(MEM_TIMEOUT);

  state_t  state, state_nxt;
  cnt_t    cnt;
  cnt_t    cnt_inc;
  logic    err_q;
  logic    set_err;
  logic    latch_req;
  logic    wb_bubble;
  word_t   req_addr, req_wdata;
  logic    req_rd, req_wr;
  logic    is_halt, memop;
  wb_sel_t wb_sel;
  wb_t     wb_d, wb_q;

  // Halt outranks a memory op if both are flagged
  assign is_halt = bus.valid_in & bus.halt_in;
  assign memop   = bus.valid_in & (bus.mem_to_reg_in | bus.memWrite_in) & ~bus.halt_in;
  assign cnt_inc = cnt + 1'b1;

  // Branch redirect and forward path only act on a live instruction in IDLE
  assign bus.pc_redirect = bus.valid_in & bus.branch_in & (state == ST_IDLE);
  assign bus.pc_target   = bus.newPC_in;
  assign bus.fwd_valid   = bus.valid_in & bus.regWrite_in & ~bus.mem_to_reg_in & (state == ST_IDLE);
  assign bus.fwd_data    = bus.enJAL_in ? bus.nextPC_in : bus.aluResult_in;
  assign bus.fwd_regsel  = bus.regsel_in;
  assign bus.err         = err_q;

  // Next state, memory drive, stall and MEM/WB bubble control
  always_comb begin
    state_nxt     = state;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.stall_out = 1'b0;
    wb_bubble     = 1'b1;
    latch_req     = 1'b0;
    set_err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_halt) begin
          wb_bubble = 1'b0;
          state_nxt = ST_HALTED;
        end else if (memop) begin
          bus.mem_addr  = bus.aluResult_in;
          bus.mem_wdata = bus.B_in;
          bus.mem_rd    = bus.mem_to_reg_in;
          bus.mem_wr    = bus.memWrite_in;
          if (bus.mem_done) begin
            wb_bubble = 1'b0;
          end else begin
            latch_req     = 1'b1;
            bus.stall_out = 1'b1;
            state_nxt     = ST_ACCESS;
          end
        end else if (bus.valid_in) begin
          wb_bubble = 1'b0;
        end
      end
      ST_ACCESS: begin
        bus.mem_addr  = req_addr;
        bus.mem_wdata = req_wdata;
        bus.mem_rd    = req_rd;
        bus.mem_wr    = req_wr;
        if (bus.mem_done) begin
          // Completion beats a coincident timeout
          wb_bubble = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          bus.stall_out = 1'b1;
          if (cnt_inc == TIMEOUT_CNT) begin
            set_err   = 1'b1;
            state_nxt = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        bus.stall_out = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Abandon any access the instant reset is applied
    if (rst) begin
      bus.mem_rd = 1'b0;
      bus.mem_wr = 1'b0;
    end
  end

  // FSM state, wait counter, sticky error and request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_rd    <= 1'b0;
      req_wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_ACCESS && !bus.mem_done) begin
        cnt <= cnt_inc;
      end else begin
        cnt <= '0;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
      if (latch_req) begin
        req_addr  <= bus.aluResult_in;
        req_wdata <= bus.B_in;
        req_rd    <= bus.mem_to_reg_in;
        req_wr    <= bus.memWrite_in;
      end
    end
  end

  assign wb_sel = bus.enJAL_in      ? WB_SEL_PC  :
                  bus.mem_to_reg_in ? WB_SEL_MEM : WB_SEL_ALU;

  assign wb_d.valid     = 1'b1;
  assign wb_d.data      = wb_mux(wb_sel, bus.aluResult_in, bus.mem_rdata, bus.nextPC_in);
  assign wb_d.regsel    = bus.regsel_in;
  assign wb_d.reg_write = bus.regWrite_in;
  assign wb_d.halt      = bus.halt_in;

  mem_stage_memwb_reg u_memwb_reg (
    .clk    (clk),
    .rst    (rst),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign bus.wb_valid    = wb_q.valid;
  assign bus.wb_data     = wb_q.data;
  assign bus.wb_regsel   = wb_q.regsel;
  assign bus.wb_regWrite = wb_q.reg_write;
  assign bus.wb_halt     = wb_q.halt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus multi-cycle sequences.
module tb_mem_stage;

  typedef struct packed {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] b;
    logic [15:0] next_pc;
    logic [15:0] new_pc;
    logic [2:0]  regsel;
    logic        en_jal;
    logic        branch;
    logic        m2r;
    logic        mwr;
    logic        rwr;
    logic        halt;
    logic [15:0] rdata;
    logic        done;
  } in_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        stall;
    logic        redir;
    logic [15:0] target;
    logic        fwd;
    logic [15:0] fwd_data;
    logic        wbv;
    logic [15:0] wbd;
    logic [2:0]  wbr;
    logic        wbrw;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_stage_if bus();

  mem_stage #(.MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input in_t v);
    bus.valid_in      = v.valid;
    bus.aluResult_in  = v.alu;
    bus.B_in          = v.b;
    bus.nextPC_in     = v.next_pc;
    bus.newPC_in      = v.new_pc;
    bus.regsel_in     = v.regsel;
    bus.enJAL_in      = v.en_jal;
    bus.branch_in     = v.branch;
    bus.mem_to_reg_in = v.m2r;
    bus.memWrite_in   = v.mwr;
    bus.regWrite_in   = v.rwr;
    bus.halt_in       = v.halt;
    bus.mem_rdata     = v.rdata;
    bus.mem_done      = v.done;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  vec_t tbl[6];
  in_t  s;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    s = '0;
    drive(s);

    // Zero-wait load
    tbl[0] = '0;
    tbl[0].i.valid = 1; tbl[0].i.alu = 16'h0040; tbl[0].i.m2r = 1; tbl[0].i.rwr = 1;
    tbl[0].i.regsel = 3'd2; tbl[0].i.rdata = 16'hBEEF; tbl[0].i.done = 1;
    tbl[0].e.rd = 1; tbl[0].e.addr = 16'h0040; tbl[0].e.fwd_data = 16'h0040;
    tbl[0].e.wbv = 1; tbl[0].e.wbd = 16'hBEEF; tbl[0].e.wbr = 3'd2; tbl[0].e.wbrw = 1;
    // Plain ALU op forwarded, memory idle, mem_rdata ignored
    tbl[1] = '0;
    tbl[1].i.valid = 1; tbl[1].i.alu = 16'h1111; tbl[1].i.rwr = 1; tbl[1].i.regsel = 3'd3;
    tbl[1].i.rdata = 16'hDEAD;
    tbl[1].e.fwd = 1; tbl[1].e.fwd_data = 16'h1111;
    tbl[1].e.wbv = 1; tbl[1].e.wbd = 16'h1111; tbl[1].e.wbr = 3'd3; tbl[1].e.wbrw = 1;
    // Branch plus JAL
    tbl[2] = '0;
    tbl[2].i.valid = 1; tbl[2].i.alu = 16'hAAAA; tbl[2].i.next_pc = 16'h0012;
    tbl[2].i.new_pc = 16'h0200; tbl[2].i.regsel = 3'd7; tbl[2].i.en_jal = 1;
    tbl[2].i.branch = 1; tbl[2].i.rwr = 1;
    tbl[2].e.redir = 1; tbl[2].e.target = 16'h0200; tbl[2].e.fwd = 1; tbl[2].e.fwd_data = 16'h0012;
    tbl[2].e.wbv = 1; tbl[2].e.wbd = 16'h0012; tbl[2].e.wbr = 3'd7; tbl[2].e.wbrw = 1;
    // Bubble with control bits set: nothing may fire
    tbl[3] = '0;
    tbl[3].i.branch = 1; tbl[3].i.rwr = 1; tbl[3].i.m2r = 1; tbl[3].i.alu = 16'h0777;
    tbl[3].e.fwd_data = 16'h0777;
    // Zero-wait store
    tbl[4] = '0;
    tbl[4].i.valid = 1; tbl[4].i.alu = 16'h0300; tbl[4].i.b = 16'h5678; tbl[4].i.mwr = 1;
    tbl[4].i.done = 1; tbl[4].i.regsel = 3'd1;
    tbl[4].e.wr = 1; tbl[4].e.addr = 16'h0300; tbl[4].e.wdata = 16'h5678; tbl[4].e.fwd_data = 16'h0300;
    tbl[4].e.wbv = 1; tbl[4].e.wbd = 16'h0300; tbl[4].e.wbr = 3'd1;
    // Taken branch without link, no register write
    tbl[5] = '0;
    tbl[5].i.valid = 1; tbl[5].i.branch = 1; tbl[5].i.new_pc = 16'h0ABC; tbl[5].i.alu = 16'h0055;
    tbl[5].i.next_pc = 16'h0020; tbl[5].i.regsel = 3'd4;
    tbl[5].e.redir = 1; tbl[5].e.target = 16'h0ABC; tbl[5].e.fwd_data = 16'h0055;
    tbl[5].e.wbv = 1; tbl[5].e.wbd = 16'h0055; tbl[5].e.wbr = 3'd4;

    // Reset state
    #2;
    chk("rst wb_valid", bus.wb_valid, 0);
    chk("rst wb_data", bus.wb_data, 0);
    chk("rst wb_regWrite", bus.wb_regWrite, 0);
    chk("rst wb_halt", bus.wb_halt, 0);
    chk("rst err", bus.err, 0);
    chk("rst mem_rd", bus.mem_rd, 0);
    chk("rst stall", bus.stall_out, 0);
    @(negedge clk); rst = 1'b0;

    // Single-cycle vectors
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(tbl[k].i);
      #1;
      chk($sformatf("v%0d mem_rd", k), bus.mem_rd, tbl[k].e.rd);
      chk($sformatf("v%0d mem_wr", k), bus.mem_wr, tbl[k].e.wr);
      if (tbl[k].e.rd || tbl[k].e.wr) chk($sformatf("v%0d mem_addr", k), bus.mem_addr, tbl[k].e.addr);
      if (tbl[k].e.wr) chk($sformatf("v%0d mem_wdata", k), bus.mem_wdata, tbl[k].e.wdata);
      chk($sformatf("v%0d stall", k), bus.stall_out, tbl[k].e.stall);
      chk($sformatf("v%0d pc_redirect", k), bus.pc_redirect, tbl[k].e.redir);
      if (tbl[k].e.redir) chk($sformatf("v%0d pc_target", k), bus.pc_target, tbl[k].e.target);
      chk($sformatf("v%0d fwd_valid", k), bus.fwd_valid, tbl[k].e.fwd);
      chk($sformatf("v%0d fwd_data", k), bus.fwd_data, tbl[k].e.fwd_data);
      chk($sformatf("v%0d fwd_regsel", k), bus.fwd_regsel, tbl[k].i.regsel);
      @(posedge clk); #1;
      chk($sformatf("v%0d wb_valid", k), bus.wb_valid, tbl[k].e.wbv);
      chk($sformatf("v%0d wb_regWrite", k), bus.wb_regWrite, tbl[k].e.wbrw);
      if (tbl[k].e.wbv) begin
        chk($sformatf("v%0d wb_data", k), bus.wb_data, tbl[k].e.wbd);
        chk($sformatf("v%0d wb_regsel", k), bus.wb_regsel, tbl[k].e.wbr);
      end
    end

    // 3-wait store; request inputs scrambled while waiting to prove the latch
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      s = '0; s.valid = 1; s.mwr = 1; s.regsel = 3'd5;
      s.alu = (c == 2 || c == 3) ? 16'hF00D : 16'h0100;
      s.b   = (c == 2 || c == 3) ? 16'h0BAD : 16'h1234;
      s.done = (c == 4);
      drive(s);
      #1;
      chk($sformatf("st%0d stall", c), bus.stall_out, (c < 4) ? 16'd1 : 16'd0);
      chk($sformatf("st%0d mem_wr", c), bus.mem_wr, 1);
      chk($sformatf("st%0d mem_rd", c), bus.mem_rd, 0);
      chk($sformatf("st%0d mem_addr", c), bus.mem_addr, 16'h0100);
      chk($sformatf("st%0d mem_wdata", c), bus.mem_wdata, 16'h1234);
      @(posedge clk); #1;
      chk($sformatf("st%0d wb_valid", c), bus.wb_valid, (c == 4) ? 16'd1 : 16'd0);
    end

    // 1-wait load returning data on completion
    @(negedge clk);
    s = '0; s.valid = 1; s.m2r = 1; s.rwr = 1; s.alu = 16'h0080; s.regsel = 3'd6;
    drive(s); #1;
    chk("ld1 stall", bus.stall_out, 1);
    chk("ld1 mem_rd", bus.mem_rd, 1);
    chk("ld1 fwd_valid", bus.fwd_valid, 0);
    @(posedge clk); #1;
    chk("ld1 wb_valid", bus.wb_valid, 0);
    @(negedge clk);
    s.done = 1; s.rdata = 16'hCAFE; drive(s); #1;
    chk("ld2 stall", bus.stall_out, 0);
    chk("ld2 mem_addr", bus.mem_addr, 16'h0080);
    @(posedge clk); #1;
    chk("ld2 wb_valid", bus.wb_valid, 1);
    chk("ld2 wb_data", bus.wb_data, 16'hCAFE);
    chk("ld2 wb_regsel", bus.wb_regsel, 6);

    // mem_done on the final allowed ACCESS cycle beats the timeout
    @(negedge clk);
    s = '0; s.valid = 1; s.m2r = 1; s.rwr = 1; s.alu = 16'h0090; s.regsel = 3'd1;
    drive(s);
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      s.done = (c == 15); s.rdata = 16'h1357; drive(s);
      @(posedge clk); #1;
    end
    chk("dw err", bus.err, 0);
    chk("dw wb_valid", bus.wb_valid, 1);
    chk("dw wb_data", bus.wb_data, 16'h1357);
    @(negedge clk);
    s = '0; drive(s); #1;
    chk("dw stall after", bus.stall_out, 0);

    // Timeout: err after 15 ACCESS cycles without mem_done
    @(negedge clk);
    s = '0; s.valid = 1; s.m2r = 1; s.rwr = 1; s.alu = 16'h00A0; s.regsel = 3'd2;
    drive(s);
    @(posedge clk);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 14) chk("to err at 14", bus.err, 0);
      if (c == 14) chk("to stall at 14", bus.stall_out, 1);
    end
    chk("to err at 15", bus.err, 1);
    @(negedge clk); #1;
    chk("to halted stall", bus.stall_out, 1);
    chk("to halted mem_rd", bus.mem_rd, 0);
    @(posedge clk); #1;
    chk("to err sticky", bus.err, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of a waiting load
    s = '0; s.valid = 1; s.rwr = 1; s.alu = 16'h4242; s.regsel = 3'd3;
    drive(s);
    @(posedge clk);
    @(negedge clk);
    s = '0; s.valid = 1; s.m2r = 1; s.rwr = 1; s.alu = 16'h00B0; s.regsel = 3'd5;
    drive(s);
    @(posedge clk);
    @(negedge clk); #1;
    chk("rm mem_rd before", bus.mem_rd, 1);
    chk("rm mem_addr before", bus.mem_addr, 16'h00B0);
    rst = 1'b1; #1;
    chk("rm mem_rd", bus.mem_rd, 0);
    chk("rm mem_wr", bus.mem_wr, 0);
    chk("rm wb_valid", bus.wb_valid, 0);
    chk("rm wb_data", bus.wb_data, 0);
    chk("rm wb_regsel", bus.wb_regsel, 0);
    chk("rm wb_regWrite", bus.wb_regWrite, 0);
    chk("rm wb_halt", bus.wb_halt, 0);
    chk("rm err", bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    s = '0; s.valid = 1; s.m2r = 1; s.rwr = 1; s.alu = 16'h00C0; s.regsel = 3'd2;
    s.done = 1; s.rdata = 16'h7777;
    drive(s); #1;
    chk("rm post mem_rd", bus.mem_rd, 1);
    chk("rm post stall", bus.stall_out, 0);
    @(posedge clk); #1;
    chk("rm post wb_valid", bus.wb_valid, 1);
    chk("rm post wb_data", bus.wb_data, 16'h7777);

    // Halt: wb_halt loads, then everything freezes
    @(negedge clk);
    s = '0; s.valid = 1; s.halt = 1; drive(s);
    @(posedge clk); #1;
    chk("hl wb_halt", bus.wb_halt, 1);
    chk("hl wb_valid", bus.wb_valid, 1);
    @(negedge clk);
    s = '0; s.valid = 1; s.m2r = 1; s.rwr = 1; s.branch = 1; s.new_pc = 16'h0400;
    s.alu = 16'h0010; s.done = 1;
    drive(s); #1;
    chk("hl mem_rd", bus.mem_rd, 0);
    chk("hl stall", bus.stall_out, 1);
    chk("hl pc_redirect", bus.pc_redirect, 0);
    @(posedge clk); #1;
    chk("hl bubble wb_valid", bus.wb_valid, 0);
    chk("hl wb_halt held", bus.wb_halt, 1);
    @(negedge clk);
    s = '0; s.valid = 1; s.mwr = 1; s.alu = 16'h0020; s.b = 16'h9999; s.done = 1;
    drive(s); #1;
    chk("hl mem_wr", bus.mem_wr, 0);
    chk("hl stall 2", bus.stall_out, 1);
    @(posedge clk); #1;
    chk("hl wb_halt held 2", bus.wb_halt, 1);
    @(negedge clk);
    s = '0; drive(s);
    rst = 1'b1; #1;
    chk("hl rst wb_halt", bus.wb_halt, 0);
    chk("hl rst stall", bus.stall_out, 0);
    @(negedge clk); rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
